// File: rtl/apb_pkg.sv
// Shared types and address-map defaults for the APB bridge and the
// peripheral address map.
package apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } apb_state_e;

  localparam logic [31:0] APB_ADDR_BASE  = 32'h1000_0000;
  localparam logic [31:0] APB_SLAVE_SIZE = 32'h0000_1000;

  // An index bus needs at least one bit, even with a single slave.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral-window decode: one-hot select, binary index and
// hit flag for a byte address.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] ADDR_BASE  = APB_ADDR_BASE,
  parameter logic [31:0] SLAVE_SIZE = APB_SLAVE_SIZE,
  localparam int         IW         = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]           i_addr,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic [IW-1:0]         o_idx,
  output logic                  o_hit
);

  localparam int SIZE_LOG2 = $clog2(SLAVE_SIZE);

  logic [31:0] w_offset;
  logic [31:0] w_slot;

  // The offset wraps for addresses below the base; the explicit compare
  // rejects those before the slot number is trusted.
  assign w_offset = i_addr - ADDR_BASE;
  assign w_slot   = w_offset >> SIZE_LOG2;
  assign o_hit    = (i_addr >= ADDR_BASE) && (w_slot < 32'(NUM_SLAVES));
  assign o_idx    = o_hit ? w_slot[IW-1:0] : '0;

  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_sel[i] = o_hit && (w_slot == 32'(i));
    end
  end

endmodule

// File: rtl/apb_master.sv
// Core data bus to APB3 bridge with address decode, slave-error pass-through
// and an ACCESS-phase timeout.
//   state  | meaning
//   IDLE   | waiting for busReq; latches address/control/data and slave index
//   SETUP  | PSEL asserted, PENABLE low
//   ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
//   DONE   | busReady pulse, busError = latched PSLVERR
//   ERR    | busReady + busError pulse (miss or timeout)
module apb_master
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] ADDR_BASE      = APB_ADDR_BASE,
  parameter logic [31:0] SLAVE_SIZE     = APB_SLAVE_SIZE,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     busReq,
  input  logic                     busWe,
  input  logic [31:0]              busAddr,
  input  logic [31:0]              busWData,
  output logic [31:0]              busRData,
  output logic                     busReady,
  output logic                     busError,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  output logic                     PENABLE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [NUM_SLAVES*32-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR
);

  localparam int             IW       = idx_width(NUM_SLAVES);
  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  apb_state_e r_state;
  apb_state_e w_next;

  logic [NUM_SLAVES-1:0] w_dec_sel;
  logic [IW-1:0]         w_dec_idx;
  logic                  w_dec_hit;

  logic [NUM_SLAVES-1:0] r_sel;
  logic [IW-1:0]         r_idx;
  logic [31:0]           r_paddr;
  logic [31:0]           r_pwdata;
  logic                  r_pwrite;
  logic [31:0]           r_rdata;
  logic                  r_slverr;
  logic [CW-1:0]         r_cnt;

  logic [31:0]           w_prdata;
  logic                  w_pready;
  logic                  w_pslverr;
  logic                  w_timeout;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_BASE  (ADDR_BASE),
    .SLAVE_SIZE (SLAVE_SIZE)
  ) u_dec (
    .i_addr (busAddr),
    .o_sel  (w_dec_sel),
    .o_idx  (w_dec_idx),
    .o_hit  (w_dec_hit)
  );

  assign w_prdata  = PRDATA[32*r_idx +: 32];
  assign w_pready  = PREADY[r_idx];
  assign w_pslverr = PSLVERR[r_idx];
  // This ACCESS cycle is the last one allowed: the count reaches the limit here.
  assign w_timeout = (r_cnt >= CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    PSEL     = '0;
    PENABLE  = 1'b0;
    busReady = 1'b0;
    busError = 1'b0;
    case (r_state)
      IDLE: begin
        if (busReq) w_next = w_dec_hit ? SETUP : ERR;
      end
      SETUP: begin
        PSEL   = r_sel;
        w_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = r_sel;
        PENABLE = 1'b1;
        if (w_pready)       w_next = DONE;
        else if (w_timeout) w_next = ERR;
      end
      DONE: begin
        busReady = 1'b1;
        busError = r_slverr;
        w_next   = IDLE;
      end
      ERR: begin
        busReady = 1'b1;
        busError = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel    <= '0;
      r_idx    <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (r_state == IDLE && busReq) begin
        r_paddr  <= busAddr;
        r_pwrite <= busWe;
        r_pwdata <= busWData;
        r_sel    <= w_dec_sel;
        r_idx    <= w_dec_idx;
      end
      if (w_next == SETUP) begin
        r_cnt <= '0;
      end else if (r_state == ACCESS && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == ACCESS && w_pready) begin
        r_slverr <= w_pslverr;
        if (!r_pwrite) r_rdata <= w_prdata;
      end
    end
  end

  assign busRData = r_rdata;
  assign PADDR    = r_paddr;
  assign PWRITE   = r_pwrite;
  assign PWDATA   = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized bench for apb_master; slaves are modelled by the
// bench and results are predicted from the address map and wait counts.
module tb_apb_master;
  import apb_pkg::*;

  localparam int          N    = 4;
  localparam int          T    = 4;
  localparam logic [31:0] BASE = APB_ADDR_BASE;
  localparam logic [31:0] SIZE = APB_SLAVE_SIZE;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            busReq = 1'b0;
  logic            busWe = 1'b0;
  logic [31:0]     busAddr = '0;
  logic [31:0]     busWData = '0;
  logic [31:0]     busRData;
  logic            busReady;
  logic            busError;
  logic [31:0]     PADDR;
  logic            PWRITE;
  logic [31:0]     PWDATA;
  logic            PENABLE;
  logic [N-1:0]    PSEL;
  logic [N*32-1:0] PRDATA = '0;
  logic [N-1:0]    PREADY;
  logic [N-1:0]    PSLVERR;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_rdata = '0;
  int          tb_waits = 0;
  logic        tb_serr = 1'b0;
  logic [N-1:0] tb_sel = '0;
  int          acc_cnt = 0;

  apb_master #(
    .NUM_SLAVES     (N),
    .ADDR_BASE      (BASE),
    .SLAVE_SIZE     (SIZE),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .busReq   (busReq),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWData (busWData),
    .busRData (busRData),
    .busReady (busReady),
    .busError (busError),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 clk = ~clk;

  // Slave model: the expected slave answers after tb_waits access cycles.
  always @(posedge clk) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

  always_comb begin
    PREADY  = (PENABLE && acc_cnt >= tb_waits) ? tb_sel : '0;
    PSLVERR = tb_serr ? tb_sel : '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after busReady.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic serr, input logic [31:0] rd);
    logic hit;
    int   idx;
    int   exp_lat, exp_psel, lat, psel_cyc, pen_cyc;
    logic exp_err, sel_bad, stable_bad;

    hit = (addr >= BASE) && (addr < BASE + N * SIZE);
    idx = hit ? int'((addr - BASE) / SIZE) : 0;
    tb_sel = '0;
    if (hit) tb_sel[idx] = 1'b1;
    tb_waits = waits;
    tb_serr  = serr;
    for (int s = 0; s < N; s++) PRDATA[s*32 +: 32] = $urandom;
    if (hit) PRDATA[idx*32 +: 32] = rd;

    if (!hit) begin
      exp_lat = 1; exp_err = 1'b1; exp_psel = 0;
    end else if (waits < T) begin
      exp_lat = 3 + waits; exp_err = serr; exp_psel = 2 + waits;
      if (!we) m_rdata = rd;
    end else begin
      exp_lat = T + 2; exp_err = 1'b1; exp_psel = T + 1;
    end

    busReq = 1'b1; busWe = we; busAddr = addr; busWData = wdata;
    lat = 0; psel_cyc = 0; pen_cyc = 0; sel_bad = 1'b0; stable_bad = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (PSEL != '0) begin
        psel_cyc++;
        if (PSEL !== tb_sel) sel_bad = 1'b1;
        if (PADDR !== addr || PWRITE !== we || PWDATA !== wdata) stable_bad = 1'b1;
      end
      if (PENABLE) pen_cyc++;
      if (busReady) begin
        lat = n;
        break;
      end
    end
    busReq = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busError", 32'(busError), 32'(exp_err));
    chk("busRData", busRData, m_rdata);
    chk("psel_cycles", 32'(psel_cyc), 32'(exp_psel));
    chk("penable_cycles", 32'(pen_cyc), 32'(hit ? exp_psel - 1 : 0));
    chk("psel_onehot", 32'(sel_bad), 32'd0);
    chk("ctrl_stable", 32'(stable_bad), 32'd0);
    @(negedge clk);
    chk("ready_width", 32'(busReady), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          cat;

    repeat (2) @(negedge clk);
    chk("rst_busRData", busRData, 32'd0);
    chk("rst_ready_err", {30'd0, busReady, busError}, 32'd0);
    chk("rst_psel_pen", {27'd0, PSEL, PENABLE}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", {PWDATA[30:0], PWRITE}, 32'd0);
    reset = 1'b1;

    xfer(1'b0, 32'h1000_1004, 32'h0,         0,   1'b0, 32'hCAFE_0001);
    xfer(1'b1, 32'h1000_3000, 32'h0000_00A5, 2,   1'b0, 32'h5555_AAAA);
    xfer(1'b0, 32'h2000_0000, 32'h0,         0,   1'b0, 32'h0);
    xfer(1'b0, 32'h1000_0000, 32'h0,         0,   1'b1, 32'h0000_1234);
    xfer(1'b0, 32'h1000_2008, 32'h0,         255, 1'b0, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h1000_2010, 32'h0,         T-1, 1'b0, 32'h0BAD_F00D);

    // Reset in the middle of an ACCESS phase to a slave that never answers.
    tb_waits = 255; tb_serr = 1'b0; tb_sel = 4'b0100;
    busReq = 1'b1; busWe = 1'b0; busAddr = 32'h1000_2000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_penable", 32'(PENABLE), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_psel_pen", {27'd0, PSEL, PENABLE}, 32'd0);
    chk("rst_mid_ready_err", {30'd0, busReady, busError}, 32'd0);
    chk("rst_mid_rdata", busRData, 32'd0);
    chk("rst_mid_paddr", PADDR, 32'd0);
    busReq = 1'b0;
    m_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_ready", 32'(busReady), 32'd0);
    end
    reset = 1'b1;
    xfer(1'b0, 32'h1000_0040, 32'h0, 1, 1'b0, 32'h7777_0001);

    for (int k = 0; k < 40; k++) begin
      cat = $urandom_range(0, 5);
      if (cat <= 3) begin
        a = BASE + 32'($urandom_range(0, N - 1)) * SIZE + ($urandom & (SIZE - 1));
      end else if (cat == 4) begin
        a = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0FFF_FFFF)
                                        : (BASE + N * SIZE + ($urandom & 32'h0FFF_FFFF));
      end else begin
        case ($urandom_range(0, 5))
          0: a = BASE - 1;
          1: a = BASE;
          2: a = BASE + N * SIZE - 1;
          3: a = BASE + N * SIZE;
          4: a = 32'hFFFF_FFFF;
          default: a = 32'h0;
        endcase
      end
      xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, T + 1),
           1'($urandom_range(0, 3) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
